alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Sequential, handshaked ALU: the responder side of the operand/opcode/result/ZCV interface our pattern benches drive.
- Accepts one operation per valid/ready transaction.
- Single-cycle ops are computed in the accept cycle and registered. Multiply (optional) is iterative, one bit per cycle.
- Result and flags are held until the consumer accepts them. Sits between an operand source (bench or issue logic) and a result sink/checker.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/opcode present.
- in_ready  output  1  block can accept; combinational: (state==IDLE) && (!out_valid || out_ready).
- src1  input  DATA_W  operand A.
- src2  input  DATA_W  operand B.
- ALU_control  input  4  opcode: 0 AND, 1 OR, 2 ADD, 3 MUL, 6 SUB, 7 SLT, 12 NOR.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result.
- result  output  DATA_W  registered result.
- zero  output  1  registered, result==0.
- cout  output  1  registered carry flag.
- overflow  output  1  registered signed-overflow flag.
- illegal  output  1  registered, opcode not supported.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; out_valid, result, zero, cout, overflow, illegal, counter and accumulator all 0.
  - in_ready=1 once rst deasserts.
  - Reset mid-multiply aborts the operation; no result is produced.
- Accept: rising edge with in_valid && in_ready. src1, src2 and ALU_control are sampled only at this edge.
- States:
  - IDLE: on accept of a non-MUL op, compute and register result/flags, set out_valid at the same edge, stay IDLE. On accept of MUL, load multiplicand/multiplier, clear accumulator and counter, go to MUL.
  - MUL: each cycle, if multiplier bit[counter] is set, add multiplicand<<counter to the 2*DATA_W accumulator; counter+1. On the cycle with counter==DATA_W-1, register low DATA_W bits as result, set out_valid, go to IDLE.
  - in_ready=0 throughout MUL.
- Latency:
  - Single-cycle ops: out_valid visible after the accept edge (1 cycle).
  - MUL: out_valid visible after accept edge + DATA_W cycles (32).
- Output hold: result/flags/illegal are stable while out_valid && !out_ready. out_valid clears at an edge with out_ready=1 unless a new single-cycle op is accepted at that same edge; in that case new results load and out_valid stays 1 (back-to-back, 1 op/cycle).
- Arithmetic:
  - ADD: {cout,result} = src1 + src2; overflow = (src1[31]==src2[31]) && (result[31]!=src1[31]).
  - SUB: {cout,result} = src1 + ~src2 + 1 (cout=1 means no borrow); overflow = (src1[31]!=src2[31]) && (result[31]!=src1[31]).
  - SLT: result = {31'b0, signed(src1)<signed(src2)}, computed overflow-safe; cout=0, overflow=0.
  - AND/OR/NOR: bitwise; cout=0, overflow=0.
  - MUL: unsigned; cout = |accumulator[2*DATA_W-1:DATA_W]; overflow=0.
  - zero = (result==0) for every op.
- Illegal opcode: single-cycle; result=0, zero=1, cout=0, overflow=0, illegal=1. illegal=0 for all supported ops.
- in_valid while in_ready=0 is ignored. The source must hold its operands until accepted.

Optional Feature:
ALU_MUL_EN
- Defined: opcode 3 runs the iterative multiply described above.
- Undefined: the MUL state, accumulator and counter are not built. Opcode 3 is treated as illegal (single-cycle, result 0, illegal=1), and in_ready never drops for it.

Test Plan:
- Reset then ADD 0x7FFFFFFF+0x00000001 -> after 1 cycle out_valid=1, result=0x80000000, ZCV=001, illegal=0.
- SUB 0x00000005-0x00000005, out_ready held 0 for 3 cycles -> result=0x00000000, ZCV=110 held stable; in_ready=0 during the hold; out_valid clears 1 cycle after out_ready=1.
- Back-to-back with out_ready=1: AND 0xF0F0F0F0,0xFF00FF00 then SLT 0xFFFFFFFF,0x00000001 then NOR 0,0 -> results 0xF000F000, 0x00000001, 0xFFFFFFFF on consecutive cycles, all ZCV=000.
- MUL 0x00010000*0x00010000 (ALU_MUL_EN) -> in_ready=0 for 32 cycles, then result=0x00000000, ZCV=110. Without the macro -> 1 cycle, illegal=1, ZCV=100.
- MUL 0x00000007*0x00000006, rst pulsed at cycle 10 -> all outputs 0 immediately, no out_valid. Repeat without reset -> result=0x0000002A, ZCV=000.
- Opcode 5, src 0x12345678/0x1 -> result=0, ZCV=100, illegal=1; next legal op OR 0x1|0x2 -> result=0x3, illegal=0.

Source files
------------

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/opcode request and result/ZCV response bundle for alu_seq
// The master side is the operand source and result sink. The slave side is the ALU.
interface alu_seq_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;
   logic [3:0]        ALU_control;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;
   logic              zero;
   logic              cout;
   logic              overflow;
   logic              illegal;

   modport master (
      output in_valid, src1, src2, ALU_control, out_ready,
      input  in_ready, out_valid, result, zero, cout, overflow, illegal
   );

   modport slave (
      input  in_valid, src1, src2, ALU_control, out_ready,
      output in_ready, out_valid, result, zero, cout, overflow, illegal
   );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential handshaked ALU; define ALU_MUL_EN to build the iterative multiply (opcode 3)
// Single-cycle ops are computed in the accept cycle and registered.
// The result and flags stay held until the consumer takes them.
module alu_seq #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic     clk,
   input  logic     rst,
   alu_seq_if.slave bus
);
   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;
   localparam logic [3:0] OP_NOR = 4'd12;
   localparam int         MSB    = DATA_W - 1;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_result;
   logic              r_zero;
   logic              r_cout;
   logic              r_overflow;
   logic              r_illegal;

   logic              w_in_ready;
   logic              w_accept;
   logic [DATA_W:0]   w_add;
   logic [DATA_W:0]   w_sub;
   logic [DATA_W-1:0] w_res;
   logic              w_cout;
   logic              w_ovf;
   logic              w_illegal;

`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd3;

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*DATA_W-1:0] r_acc;
   logic [2*DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0]   r_mplr;
   logic [2*DATA_W-1:0] w_acc_next;
   logic                w_is_mul;

   // The multiplicand shifts left and the multiplier shifts right each cycle, so bit 0 selects the partial product.
   assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : '0);
   assign w_is_mul   = (bus.ALU_control == OP_MUL);
   assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
`else
   assign w_in_ready = !r_out_valid || bus.out_ready;
`endif

   assign w_accept = bus.in_valid && w_in_ready;
   assign w_add    = {1'b0, bus.src1} + {1'b0, bus.src2};
   assign w_sub    = {1'b0, bus.src1} + {1'b0, ~bus.src2} + {{DATA_W{1'b0}}, 1'b1};

   // Single-cycle result and flags for the opcode currently presented.
   always_comb begin
      w_res     = '0;
      w_cout    = 1'b0;
      w_ovf     = 1'b0;
      w_illegal = 1'b0;
      case (bus.ALU_control)
         OP_AND: w_res = bus.src1 & bus.src2;
         OP_OR:  w_res = bus.src1 | bus.src2;
         OP_NOR: w_res = ~(bus.src1 | bus.src2);
         OP_ADD: begin
            w_res  = w_add[DATA_W-1:0];
            w_cout = w_add[DATA_W];
            w_ovf  = (bus.src1[MSB] == bus.src2[MSB]) && (w_add[MSB] != bus.src1[MSB]);
         end
         OP_SUB: begin
            w_res  = w_sub[DATA_W-1:0];
            w_cout = w_sub[DATA_W];
            w_ovf  = (bus.src1[MSB] != bus.src2[MSB]) && (w_sub[MSB] != bus.src1[MSB]);
         end
         // A signed compare cannot overflow, unlike a subtract-and-test-sign implementation.
         OP_SLT: w_res = {{(DATA_W-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
         default: w_illegal = 1'b1;
      endcase
   end

   // Control and output registers: accept, multiply iterations, and the output hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_cout      <= 1'b0;
         r_overflow  <= 1'b0;
         r_illegal   <= 1'b0;
`ifdef ALU_MUL_EN
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplr      <= '0;
`endif
      end else begin
`ifdef ALU_MUL_EN
         if (r_state == S_MUL) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
               r_result    <= w_acc_next[DATA_W-1:0];
               r_zero      <= (w_acc_next[DATA_W-1:0] == '0);
               r_cout      <= |w_acc_next[2*DATA_W-1:DATA_W];
               r_overflow  <= 1'b0;
               r_illegal   <= 1'b0;
               r_out_valid <= 1'b1;
               r_state     <= S_IDLE;
            end
         end else if (w_accept && w_is_mul) begin
            // Any previous result was taken or absent at this edge, because in_ready requires it.
            r_mcand     <= {{DATA_W{1'b0}}, bus.src1};
            r_mplr      <= bus.src2;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_state     <= S_MUL;
         end else
`endif
         if (w_accept) begin
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_cout      <= w_cout;
            r_overflow  <= w_ovf;
            r_illegal   <= w_illegal;
            r_out_valid <= 1'b1;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.cout      = r_cout;
   assign bus.overflow  = r_overflow;
   assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (expectations follow ALU_MUL_EN)
module tb_alu_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errs   = 0;
   int   lat;
   logic seen;

   alu_seq_if #(.DATA_W(32)) bus ();

   alu_seq #(.DATA_W(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid    = 1'b1;
      bus.ALU_control = op;
      bus.src1        = a;
      bus.src2        = b;
   endtask

   task automatic wait_result();
      lat  = 0;
      seen = 1'b0;
      while (!bus.out_valid && lat < 40) begin
         seen = seen | bus.in_ready;
         tick();
         lat++;
      end
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.ALU_control = 4'd0;
      bus.src1        = '0;
      bus.src2        = '0;
      bus.out_ready   = 1'b0;
      tick();
      tick();
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b000);
      chk("rst_illegal", bus.illegal, 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);

      // ADD with signed overflow
      drive(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
      tick();
      bus.in_valid = 1'b0;
      chk("add_valid", bus.out_valid, 1);
      chk("add_result", bus.result, 32'h8000_0000);
      chk("add_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b001);
      chk("add_illegal", bus.illegal, 0);
      chk("add_in_ready_hold", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      tick();
      chk("add_clear", bus.out_valid, 0);
      bus.out_ready = 1'b0;

      // SUB held for 3 cycles while a different op is offered and must be ignored
      drive(4'd6, 32'h0000_0005, 32'h0000_0005);
      tick();
      drive(4'd0, 32'h0000_FFFF, 32'h0000_FFFF);
      for (int i = 0; i < 3; i++) begin
         chk("sub_hold_valid", bus.out_valid, 1);
         chk("sub_hold_result", bus.result, 32'h0);
         chk("sub_hold_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b110);
         chk("sub_hold_in_ready", bus.in_ready, 0);
         tick();
      end
      chk("sub_hold_end", bus.result, 32'h0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("sub_clear", bus.out_valid, 0);

      // Back-to-back single-cycle ops
      drive(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
      tick();
      chk("and_result", bus.result, 32'hF000_F000);
      chk("and_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b000);
      chk("b2b_in_ready", bus.in_ready, 1);
      drive(4'd7, 32'hFFFF_FFFF, 32'h0000_0001);
      tick();
      chk("slt_valid", bus.out_valid, 1);
      chk("slt_result", bus.result, 32'h0000_0001);
      chk("slt_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b000);
      drive(4'd12, 32'h0, 32'h0);
      tick();
      bus.in_valid = 1'b0;
      chk("nor_result", bus.result, 32'hFFFF_FFFF);
      chk("nor_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b000);
      tick();
      chk("b2b_clear", bus.out_valid, 0);

      // MUL with the product entirely in the upper half
      bus.out_ready = 1'b0;
      drive(4'd3, 32'h0001_0000, 32'h0001_0000);
      tick();
      bus.in_valid = 1'b0;
`ifdef ALU_MUL_EN
      wait_result();
      chk("mul_latency", lat, 32);
      chk("mul_in_ready_low", seen, 0);
      chk("mul_result", bus.result, 32'h0);
      chk("mul_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b110);
      chk("mul_illegal", bus.illegal, 0);
`else
      chk("mul_valid", bus.out_valid, 1);
      chk("mul_result", bus.result, 32'h0);
      chk("mul_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b100);
      chk("mul_illegal", bus.illegal, 1);
`endif
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("mul_clear", bus.out_valid, 0);

      // MUL aborted by reset in the middle
      drive(4'd3, 32'h0000_0007, 32'h0000_0006);
      tick();
      bus.in_valid = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      #1;
      chk("abort_valid", bus.out_valid, 0);
      chk("abort_result", bus.result, 0);
      chk("abort_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b000);
      chk("abort_illegal", bus.illegal, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("abort_in_ready", bus.in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen = seen | bus.out_valid;
         tick();
      end
      chk("abort_no_result", seen, 0);

      // Same MUL without reset
      drive(4'd3, 32'h0000_0007, 32'h0000_0006);
      tick();
      bus.in_valid = 1'b0;
`ifdef ALU_MUL_EN
      wait_result();
      chk("mul2_latency", lat, 32);
      chk("mul2_result", bus.result, 32'h0000_002A);
      chk("mul2_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b000);
`else
      chk("mul2_result", bus.result, 32'h0);
      chk("mul2_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b100);
      chk("mul2_illegal", bus.illegal, 1);
`endif
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // Illegal opcode, then a legal op back-to-back
      drive(4'd5, 32'h1234_5678, 32'h0000_0001);
      tick();
      chk("ill_valid", bus.out_valid, 1);
      chk("ill_result", bus.result, 32'h0);
      chk("ill_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b100);
      chk("ill_flag", bus.illegal, 1);
      bus.out_ready = 1'b1;
      drive(4'd1, 32'h0000_0001, 32'h0000_0002);
      tick();
      bus.in_valid = 1'b0;
      chk("or_valid", bus.out_valid, 1);
      chk("or_result", bus.result, 32'h0000_0003);
      chk("or_zcv", {bus.zero, bus.cout, bus.overflow}, 3'b000);
      chk("or_illegal", bus.illegal, 0);
      tick();
      chk("or_clear", bus.out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
